// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 passive matrix keypad one column at a time.
// It debounces presses and releases over whole scan dwells, then reports a
// hex key code with a one-cycle valid strobe and a held flag.
module keypad_scanner #(
  parameter int SCAN_DIV        = 48000,
  parameter int DEBOUNCE_DWELLS = 20
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_DWELLS + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_DWELLS);
  localparam logic [CW-1:0] DB_ONE     = CW'(1);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] PRESS_DB = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] REL_DB   = 2'd3;

  logic [3:0]    rows_meta;
  logic [3:0]    rs;
  logic [DW-1:0] dwell;
  logic          sample;
  logic [1:0]    col_idx;
  logic [1:0]    state;
  logic [3:0]    cand;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] db_next;
  logic          rs_idle;
  logic          rs_single;
  logic [1:0]    rs_row;

  // Hex code for a key at matrix position [row][col].
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    key_map = 4'h0;
    case ({r, c})
      4'h0: key_map = 4'h1;
      4'h1: key_map = 4'h2;
      4'h2: key_map = 4'h3;
      4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;
      4'h5: key_map = 4'h5;
      4'h6: key_map = 4'h6;
      4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;
      4'h9: key_map = 4'h8;
      4'hA: key_map = 4'h9;
      4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;
      4'hD: key_map = 4'h0;
      4'hE: key_map = 4'hF;
      4'hF: key_map = 4'hD;
      default: key_map = 4'h0;
    endcase
  endfunction

  assign cols    = ~(4'b0001 << col_idx);
  assign sample  = (dwell == DWELL_LAST);
  assign rs_idle = (rs == 4'b1111);
  assign db_next = db_cnt + DB_ONE;

  // Two-flop synchronizer for the asynchronous row lines; idles high.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      rows_meta <= 4'b1111;
      rs        <= 4'b1111;
    end else begin
      rows_meta <= rows;
      rs        <= rows_meta;
    end
  end

  // Dwell counter: one full wrap per column slot, sampling on the last count.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      dwell <= '0;
    end else if (sample) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + DWELL_ONE;
    end
  end

  // Classify a synchronized sample: exactly one low row gives its row index.
  always_comb begin
    rs_single = 1'b0;
    rs_row    = 2'd0;
    case (rs)
      4'b1110: begin rs_single = 1'b1; rs_row = 2'd0; end
      4'b1101: begin rs_single = 1'b1; rs_row = 2'd1; end
      4'b1011: begin rs_single = 1'b1; rs_row = 2'd2; end
      4'b0111: begin rs_single = 1'b1; rs_row = 2'd3; end
      default: begin rs_single = 1'b0; rs_row = 2'd0; end
    endcase
  end

  // Scan/debounce state machine; acts only on sample cycles, freezing the
  // column from the first detection until the release is debounced.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      cand      <= 4'b1111;
      db_cnt    <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (sample) begin
        case (state)
          SCAN: begin
            if (rs_single) begin
              cand <= rs;
              if (DEBOUNCE_DWELLS == 1) begin
                key       <= key_map(rs_row, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                db_cnt    <= '0;
                state     <= HELD;
              end else begin
                db_cnt <= DB_ONE;
                state  <= PRESS_DB;
              end
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end
          PRESS_DB: begin
            if (rs == cand) begin
              if (db_next == DB_LAST) begin
                key       <= key_map(rs_row, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                db_cnt    <= '0;
                state     <= HELD;
              end else begin
                db_cnt <= db_next;
              end
            end else begin
              state   <= SCAN;
              col_idx <= col_idx + 2'd1;
            end
          end
          HELD: begin
            if (rs_idle) begin
              if (DEBOUNCE_DWELLS == 1) begin
                key_held <= 1'b0;
                col_idx  <= col_idx + 2'd1;
                state    <= SCAN;
              end else begin
                db_cnt <= DB_ONE;
                state  <= REL_DB;
              end
            end else begin
              db_cnt <= '0;
            end
          end
          REL_DB: begin
            if (rs_idle) begin
              if (db_next == DB_LAST) begin
                key_held <= 1'b0;
                col_idx  <= col_idx + 2'd1;
                db_cnt   <= '0;
                state    <= SCAN;
              end else begin
                db_cnt <= db_next;
              end
            end else begin
              db_cnt <= '0;
              state  <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
